// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing the debug module's single system-bus master port
// between NumReq requesters. Define DM_SBA_ARB_TIMEOUT_EN to add a response timeout.
module dm_sba_arbiter #(
  parameter int BusWidth      = 32,
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq*BusWidth-1:0]   add_i,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq*BusWidth-1:0]   wdata_i,
  input  logic [NumReq*BusWidth/8-1:0] be_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            r_valid_o,
  output logic [BusWidth-1:0]          r_rdata_o,
  output logic                         r_err_o,
  output logic                         master_req_o,
  output logic [BusWidth-1:0]          master_add_o,
  output logic                         master_we_o,
  output logic [BusWidth-1:0]          master_wdata_o,
  output logic [BusWidth/8-1:0]        master_be_o,
  input  logic                         master_gnt_i,
  input  logic                         master_r_valid_i,
  input  logic [BusWidth-1:0]          master_r_rdata_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int BeW  = BusWidth / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e          state_q;
  logic [IdxW-1:0] prio_q;
  logic [IdxW-1:0] owner_q;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] sel;
  logic            any_req;

`ifdef DM_SBA_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;
  logic            timeout_hit;

  assign timeout_hit = (state_q == RESP) && !master_r_valid_i &&
                       (cnt_q == CntW'(TimeoutCycles - 1));
`endif

  function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] w);
    if (int'(w) == NumReq - 1) return '0;
    else return w + 1'b1;
  endfunction

  // Scanning downward so the requester closest to prio_q is the last (winning) hit.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = prio_q;
    any_req = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      idx = (int'(prio_q) + i) % NumReq;
      if (req_i[idx]) begin
        winner  = IdxW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign sel = (state_q == IDLE) ? winner : owner_q;

  always_comb begin
    master_req_o   = 1'b0;
    master_add_o   = '0;
    master_we_o    = 1'b0;
    master_wdata_o = '0;
    master_be_o    = '0;
    gnt_o          = '0;
    r_valid_o      = '0;
    r_rdata_o      = '0;
    r_err_o        = 1'b0;
    if (!rst_i) begin
      if (state_q != IDLE || any_req) begin
        master_add_o   = add_i[sel*BusWidth +: BusWidth];
        master_we_o    = we_i[sel];
        master_wdata_o = wdata_i[sel*BusWidth +: BusWidth];
        master_be_o    = be_i[sel*BeW +: BeW];
      end
      case (state_q)
        IDLE: begin
          if (any_req) begin
            master_req_o = 1'b1;
            if (master_gnt_i) gnt_o[winner] = 1'b1;
          end
        end
        REQ: begin
          if (req_i[owner_q]) begin
            master_req_o = 1'b1;
            if (master_gnt_i) gnt_o[owner_q] = 1'b1;
          end
        end
        RESP: begin
          if (master_r_valid_i) begin
            r_valid_o[owner_q] = 1'b1;
            r_rdata_o          = master_r_rdata_i;
          end
`ifdef DM_SBA_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            r_valid_o[owner_q] = 1'b1;
            r_err_o            = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // A requester dropping req_i while locked releases the bus without moving prio.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      owner_q <= '0;
`ifdef DM_SBA_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            if (master_gnt_i) begin
              prio_q  <= inc_idx(winner);
              state_q <= RESP;
`ifdef DM_SBA_ARB_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (!req_i[owner_q]) begin
            state_q <= IDLE;
          end else if (master_gnt_i) begin
            prio_q  <= inc_idx(owner_q);
            state_q <= RESP;
`ifdef DM_SBA_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        RESP: begin
          if (master_r_valid_i) begin
            state_q <= IDLE;
          end
`ifdef DM_SBA_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_sba_arbiter.sv
// Scoreboard bench for dm_sba_arbiter: two requesters, scripted bus-side grant/response.
module tb_dm_sba_arbiter;

  localparam int BW = 32;
  localparam int NR = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_i;
  logic [NR*BW-1:0] add_i;
  logic [NR-1:0]   we_i;
  logic [NR*BW-1:0] wdata_i;
  logic [NR*BW/8-1:0] be_i;
  logic [NR-1:0]   gnt_o;
  logic [NR-1:0]   r_valid_o;
  logic [BW-1:0]   r_rdata_o;
  logic            r_err_o;
  logic            master_req_o;
  logic [BW-1:0]   master_add_o;
  logic            master_we_o;
  logic [BW-1:0]   master_wdata_o;
  logic [BW/8-1:0] master_be_o;
  logic            master_gnt_i;
  logic            master_r_valid_i;
  logic [BW-1:0]   master_r_rdata_i;

  typedef struct {
    logic [NR-1:0] vmask;
    logic          err;
    logic [BW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  resp_t e;
  int    checks = 0;
  int    errors = 0;

  dm_sba_arbiter #(.BusWidth(BW), .NumReq(NR), .TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_err_o(r_err_o), .master_req_o(master_req_o),
    .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    req_i = '0; we_i = '0; add_i = '0; wdata_i = '0; be_i = '0;
    master_gnt_i = 1'b0; master_r_valid_i = 1'b0; master_r_rdata_i = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_i = 1'b1;
    bus_idle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic push_exp(input int who, input logic err, input logic [BW-1:0] data);
    resp_t r;
    r.vmask = NR'(1) << who;
    r.err   = err;
    r.data  = data;
    exp_q.push_back(r);
  endtask

  task automatic test_reset();
    req_i = 2'b11; master_gnt_i = 1'b1; master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'hFFFF_FFFF; add_i = {32'h1111_1111, 32'h2222_2222};
    @(negedge clk_i);
    checks++;
    if ({master_req_o, gnt_o, r_valid_o, r_err_o} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got req=%b gnt=%b rv=%b err=%b, want all 0",
                         master_req_o, gnt_o, r_valid_o, r_err_o);
    end
    checks++;
    if ({r_rdata_o, master_add_o, master_we_o, master_wdata_o, master_be_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got rdata=%h add=%h we=%b wdata=%h be=%h, want 0",
                         r_rdata_o, master_add_o, master_we_o, master_wdata_o, master_be_o);
    end
    next_cycle();
    rst_i = 1'b0;
    bus_idle();
  endtask

  task automatic test_single();
    next_cycle();
    req_i = 2'b01; add_i[0 +: BW] = 32'h0000_1000; master_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({master_req_o, master_add_o, gnt_o} !== {1'b1, 32'h0000_1000, 2'b01}) begin
      errors++; $display("[TB] FAIL single_grant: got req=%b add=%h gnt=%b, want 1 00001000 01",
                         master_req_o, master_add_o, gnt_o);
    end
    push_exp(0, 1'b0, 32'hDEAD_BEEF);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      req_i = '0; master_gnt_i = 1'b0;
      master_r_valid_i = (c == 3); master_r_rdata_i = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk_i);
      if (c < 3) begin
        checks++;
        if ({master_req_o, r_valid_o, r_rdata_o} !== '0) begin
          errors++; $display("[TB] FAIL single_wait%0d: got req=%b rv=%b rdata=%h, want 0",
                             c, master_req_o, r_valid_o, r_rdata_o);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
          errors++; $display("[TB] FAIL single_resp: got rv=%b err=%b rdata=%h, want rv=%b err=%b rdata=%h",
                             r_valid_o, r_err_o, r_rdata_o, e.vmask, e.err, e.data);
        end
      end
    end
    next_cycle();
    bus_idle();
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h5555_5555;
    @(negedge clk_i);
    checks++;
    if (r_valid_o !== 2'b00 || r_rdata_o !== 32'h0) begin
      errors++; $display("[TB] FAIL idle_rvalid_dropped: got rv=%b rdata=%h, want 00 0", r_valid_o, r_rdata_o);
    end
  endtask

  task automatic test_round_robin();
    int rr_prio;
    int w;
    do_reset();
    rr_prio = 0;
    for (int g = 0; g < 4; g++) begin
      w = req_i[rr_prio] ? rr_prio : (rr_prio + 1) % NR;
      next_cycle();
      req_i = 2'b11; add_i = {32'h0000_3000, 32'h0000_2000};
      master_gnt_i = 1'b1; master_r_valid_i = 1'b0;
      w = rr_prio;
      rr_prio = (w + 1) % NR;
      @(negedge clk_i);
      checks++;
      if (gnt_o !== (NR'(1) << w) || master_add_o !== (w == 0 ? 32'h0000_2000 : 32'h0000_3000)) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got gnt=%b add=%h, want requester %0d", g, gnt_o, master_add_o, w);
      end
      push_exp(w, 1'b0, 32'hA000_0000 + g);
      next_cycle();
      master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'hA000_0000 + g;
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
        errors++; $display("[TB] FAIL rr_resp%0d: got rv=%b err=%b rdata=%h, want rv=%b err=%b rdata=%h",
                           g, r_valid_o, r_err_o, r_rdata_o, e.vmask, e.err, e.data);
      end
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_grant_lock();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      req_i = (c >= 2) ? 2'b11 : 2'b01;
      add_i = {32'h0000_5000, 32'h0000_4000};
      master_gnt_i = (c == 4);
      @(negedge clk_i);
      checks++;
      if ({master_req_o, master_add_o, gnt_o} !== {1'b1, 32'h0000_4000, (c == 4) ? 2'b01 : 2'b00}) begin
        errors++; $display("[TB] FAIL lock_cycle%0d: got req=%b add=%h gnt=%b, want 1 00004000 gnt=%b",
                           c, master_req_o, master_add_o, gnt_o, (c == 4) ? 2'b01 : 2'b00);
      end
    end
    push_exp(0, 1'b0, 32'h1111_0000);
    next_cycle();
    req_i = 2'b10; master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h1111_0000;
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
      errors++; $display("[TB] FAIL lock_resp0: got rv=%b rdata=%h, want rv=%b rdata=%h", r_valid_o, r_rdata_o, e.vmask, e.data);
    end
    next_cycle();
    master_r_valid_i = 1'b0; master_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b10 || master_add_o !== 32'h0000_5000) begin
      errors++; $display("[TB] FAIL lock_grant1: got gnt=%b add=%h, want 10 00005000", gnt_o, master_add_o);
    end
    push_exp(1, 1'b0, 32'h2222_0000);
    next_cycle();
    req_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h2222_0000;
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
      errors++; $display("[TB] FAIL lock_resp1: got rv=%b rdata=%h, want rv=%b rdata=%h", r_valid_o, r_rdata_o, e.vmask, e.data);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_write_routing();
    next_cycle();
    req_i = 2'b10; we_i = 2'b10; add_i[BW +: BW] = 32'h0000_6000;
    wdata_i[BW +: BW] = 32'h1234_5678; be_i[4 +: 4] = 4'b0011; master_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({gnt_o, master_we_o, master_wdata_o, master_be_o} !== {2'b10, 1'b1, 32'h1234_5678, 4'b0011}) begin
      errors++; $display("[TB] FAIL write_payload: got gnt=%b we=%b wdata=%h be=%b, want 10 1 12345678 0011",
                         gnt_o, master_we_o, master_wdata_o, master_be_o);
    end
    push_exp(1, 1'b0, 32'h0);
    next_cycle();
    req_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h0;
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
      errors++; $display("[TB] FAIL write_resp: got rv=%b err=%b, want rv=%b err=%b", r_valid_o, r_err_o, e.vmask, e.err);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_req_drop();
    do_reset();
    next_cycle();
    req_i = 2'b01; add_i = {32'h0000_8000, 32'h0000_7000};
    next_cycle();
    req_i = 2'b00; master_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (master_req_o !== 1'b0 || gnt_o !== 2'b00) begin
      errors++; $display("[TB] FAIL drop_release: got req=%b gnt=%b, want 0 00", master_req_o, gnt_o);
    end
    next_cycle();
    req_i = 2'b11;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b01 || master_add_o !== 32'h0000_7000) begin
      errors++; $display("[TB] FAIL drop_prio_kept: got gnt=%b add=%h, want 01 00007000", gnt_o, master_add_o);
    end
    push_exp(0, 1'b0, 32'h3333_0000);
    next_cycle();
    req_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h3333_0000;
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
      errors++; $display("[TB] FAIL drop_resp: got rv=%b rdata=%h, want rv=%b rdata=%h", r_valid_o, r_rdata_o, e.vmask, e.data);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle();
    req_i = 2'b10; add_i = {32'h0000_A000, 32'h0000_9000}; master_gnt_i = 1'b1;
    next_cycle();
    rst_i = 1'b1; req_i = '0; master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h0000_0BAD;
    @(negedge clk_i);
    checks++;
    if ({master_req_o, gnt_o, r_valid_o, r_err_o, r_rdata_o, master_add_o} !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got req=%b gnt=%b rv=%b rdata=%h add=%h, want 0",
                         master_req_o, gnt_o, r_valid_o, r_rdata_o, master_add_o);
    end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (r_valid_o !== 2'b00) begin
      errors++; $display("[TB] FAIL midreset_discard: got rv=%b, want 00", r_valid_o);
    end
    next_cycle();
    master_r_valid_i = 1'b0; req_i = 2'b11; master_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (gnt_o !== 2'b01 || master_add_o !== 32'h0000_9000) begin
      errors++; $display("[TB] FAIL midreset_prio: got gnt=%b add=%h, want 01 00009000", gnt_o, master_add_o);
    end
    push_exp(0, 1'b0, 32'h4444_0000);
    next_cycle();
    req_i = '0; master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h4444_0000;
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
      errors++; $display("[TB] FAIL midreset_resp: got rv=%b rdata=%h, want rv=%b rdata=%h", r_valid_o, r_rdata_o, e.vmask, e.data);
    end
    next_cycle();
    bus_idle();
  endtask

`ifdef DM_SBA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      next_cycle();
      req_i = 2'b01; add_i[0 +: BW] = 32'h0000_B000; master_gnt_i = 1'b1;
      if (pass == 0) push_exp(0, 1'b1, 32'h0);
      else push_exp(0, 1'b0, 32'h6666_0000);
      for (int c = 0; c < 8; c++) begin
        next_cycle();
        req_i = '0; master_gnt_i = 1'b0;
        master_r_valid_i = (pass == 1 && c == 7); master_r_rdata_i = 32'h6666_0000;
        @(negedge clk_i);
        if (c < 7) begin
          checks++;
          if (r_valid_o !== 2'b00) begin
            errors++; $display("[TB] FAIL timeout_early%0d_%0d: got rv=%b, want 00", pass, c, r_valid_o);
          end
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({r_valid_o, r_err_o, r_rdata_o} !== {e.vmask, e.err, e.data}) begin
            errors++; $display("[TB] FAIL timeout_resp%0d: got rv=%b err=%b rdata=%h, want rv=%b err=%b rdata=%h",
                               pass, r_valid_o, r_err_o, r_rdata_o, e.vmask, e.err, e.data);
          end
        end
      end
      next_cycle();
      master_r_valid_i = 1'b1; master_r_rdata_i = 32'h7777_0000;
      @(negedge clk_i);
      checks++;
      if (r_valid_o !== 2'b00 || r_err_o !== 1'b0) begin
        errors++; $display("[TB] FAIL timeout_late%0d: got rv=%b err=%b, want 00 0", pass, r_valid_o, r_err_o);
      end
      next_cycle();
      bus_idle();
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    bus_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_grant_lock();
    test_write_routing();
    test_req_drop();
    test_reset_mid();
`ifdef DM_SBA_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_empty: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_sba_arbiter.md
Name: dm_sba_arbiter

Overview:
- Shares the single system-bus master port of the debug module (req/gnt/r_valid protocol, one outstanding transaction) between NumReq requesters, e.g. the SBA engine and a program-buffer/abstract-command memory access path.
- Round-robin arbitration, grant locked from request to response.
- Routes the read response back to the requester that owns the transaction.
- Sits between the requesters and the SoC bus adapter.

Parameters:
- BusWidth, 32, address/data width in bits; BusWidth/8 byte enables.
- NumReq, 2, number of requesters, minimum 2.
- TimeoutCycles, 1024, response timeout in clock cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  NumReq  per-requester request.
- add_i  in  NumReq*BusWidth  packed addresses; requester k at [k*BusWidth +: BusWidth].
- we_i  in  NumReq  per-requester write enable.
- wdata_i  in  NumReq*BusWidth  packed write data.
- be_i  in  NumReq*BusWidth/8  packed byte enables.
- gnt_o  out  NumReq  one-hot grant to requester.
- r_valid_o  out  NumReq  one-hot response valid to requester.
- r_rdata_o  out  BusWidth  response data, shared by all requesters.
- r_err_o  out  1  response error, qualified by any r_valid_o bit.
- master_req_o  out  1  bus request.
- master_add_o  out  BusWidth  bus address.
- master_we_o  out  1  bus write enable.
- master_wdata_o  out  BusWidth  bus write data.
- master_be_o  out  BusWidth/8  bus byte enables.
- master_gnt_i  in  1  bus grant.
- master_r_valid_i  in  1  bus response valid; asserted for reads and writes.
- master_r_rdata_i  in  BusWidth  bus read data.

Behaviour:
- Reset: state IDLE, prio pointer 0, owner 0. All outputs 0: master_req_o, gnt_o, r_valid_o, r_err_o, r_rdata_o, master_add_o, master_we_o, master_wdata_o, master_be_o.
- Requester protocol: hold req_i and its payload stable until gnt_o; then wait for r_valid_o before the next request.
- Arbitration:
  - Combinational round-robin.
  - Winner = first k with req_i[k]=1 searching prio, prio+1, … modulo NumReq.
  - prio <= winner+1 (mod NumReq) on every master grant.
- Master payload:
  - IDLE: muxed from the winner, or 0 when there is no request.
  - REQ/RESP: muxed from the registered owner.
- States:
  - IDLE: if any req_i, drive master_req_o=1 with winner payload in the same cycle (zero-cycle latency).
    - master_gnt_i=1: gnt_o[winner]=1, owner<=winner, go to RESP.
    - Otherwise: owner<=winner, go to REQ (lock).
  - REQ: master_req_o=1 with owner payload. A new higher-priority request does not preempt.
    - master_gnt_i: gnt_o[owner]=1, go to RESP.
    - req_i[owner] drops (protocol violation): master_req_o=0 that cycle, no grant, prio unchanged, go to IDLE.
  - RESP: master_req_o=0.
    - master_r_valid_i: r_valid_o[owner]=1, r_rdata_o=master_r_rdata_i, r_err_o=0, go to IDLE.
    - Earliest next grant is the cycle after the response; no overlap.
- Simultaneous events:
  - gnt and r_valid in the same cycle while in REQ: r_valid is ignored, because a response cannot precede its grant.
  - master_r_valid_i in IDLE or REQ: discarded, no r_valid_o.
- gnt_o and r_valid_o are each at most one-hot. r_rdata_o = 0 when no r_valid_o bit is set.
- Reset mid-operation: immediately to IDLE and the reset values above; an in-flight response is discarded.

Optional Feature:
- Macro DM_SBA_ARB_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TimeoutCycles+1) clears on entering RESP and increments each RESP cycle without master_r_valid_i.
  - When the count reaches TimeoutCycles-1 with no response, the next cycle asserts r_valid_o[owner]=1, r_err_o=1, r_rdata_o=0, and returns to IDLE.
  - Prio has already advanced at the grant.
  - A late master_r_valid_i after timeout arrives in IDLE and is discarded.
  - r_valid on the final counted cycle wins: normal response, r_err_o=0.
- Undefined: no counter; RESP waits indefinitely; r_err_o tied 0.

Test Plan:
- Single requester: req_i=2'b01, add=0x1000, we=0, master_gnt_i same cycle → master_req_o=1, add=0x1000, gnt_o=01 that cycle. r_valid 3 cycles later with rdata 0xDEADBEEF → r_valid_o=01, r_rdata_o=0xDEADBEEF, back to IDLE.
- Round-robin: both requesters hold req_i=11 from reset, bus grants each cycle it sees a request, response 1 cycle after each grant → grant order 0,1,0,1; master_add_o alternates between the two addresses.
- Grant lock: req0 asserted, master_gnt_i low 4 cycles. req1 asserts in cycle 2 → master_add_o stays req0's address; gnt_o=01 only when master_gnt_i rises; req1 is granted after req0's response.
- Write routing: requester 1 write, wdata=0x12345678, be=4'b0011 → master_we_o=1, master_wdata_o=0x12345678, master_be_o=0011. Response → r_valid_o=10, r_err_o=0.
- Reset mid-transaction: rst_i pulsed while in RESP, then master_r_valid_i=1 → all outputs 0, no r_valid_o, next request arbitrated from prio 0.
- With DM_SBA_ARB_TIMEOUT_EN and TimeoutCycles=8: grant, no response → r_valid_o[owner]=1 and r_err_o=1 exactly 8 cycles after entering RESP. A later master_r_valid_i is ignored.
